// File: rtl/reflet_gpio_int_periph.sv
// rtl/reflet_gpio_int_periph.sv - 16-bit GPIO with edge interrupts and a 3-source interrupt mux
module reflet_gpio_int_periph #(
  parameter int                       base_addr_size = 7,
  parameter logic [base_addr_size-1:0] gpio_base     = 7'h00,
  parameter logic [base_addr_size-1:0] int_base      = 7'h08
) (
  input  logic                      clk,
  input  logic                      reset,
  input  logic                      enable,
  input  logic [base_addr_size-1:0] addr,
  input  logic                      write_en,
  input  logic [7:0]                data_in,
  output logic [7:0]                data_out,
  input  logic [15:0]               gpi,
  output logic [15:0]               gpo,
  input  logic                      uart_int_in,
  input  logic                      timer_int_in,
  output logic                      gpio_int,
  output logic [3:0]                cpu_int
);

  localparam logic [base_addr_size-1:0] gpio_span = base_addr_size'(8);
  localparam logic [base_addr_size-1:0] int_span  = base_addr_size'(3);

  logic [15:0] sync_a;
  logic [15:0] sync_now;
  logic [15:0] sync_prev;
  logic [15:0] mask;
  logic [15:0] pending;
  logic [7:0]  route_gpio;
  logic [7:0]  route_uart;
  logic [7:0]  route_timer;

  logic [base_addr_size-1:0] goff;
  logic [base_addr_size-1:0] ioff;
  logic                      gpio_hit;
  logic                      int_hit;
  logic                      wr;
  logic [15:0]               rise;
  logic [15:0]               w1c;
  logic [7:0]                route_wdata;

  // Window decode: offsets wrap below the base, so a single unsigned compare bounds each window.
  always_comb begin
    goff     = addr - gpio_base;
    ioff     = addr - int_base;
    gpio_hit = enable && (goff < gpio_span);
    int_hit  = enable && (ioff < int_span);
    wr       = write_en;
    rise     = sync_now & ~sync_prev;
    route_wdata = {data_in[7], 5'b00000, data_in[1:0]};
    w1c = 16'h0000;
    if (gpio_hit && wr && goff[2:0] == 3'd6) w1c[7:0]  = data_in;
    if (gpio_hit && wr && goff[2:0] == 3'd7) w1c[15:8] = data_in;
  end

  // Input synchronizer plus the delayed copy used for rising-edge detection.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      sync_a    <= 16'h0000;
      sync_now  <= 16'h0000;
      sync_prev <= 16'h0000;
    end else begin
      sync_a    <= gpi;
      sync_now  <= sync_a;
      sync_prev <= sync_now;
    end
  end

  // GPIO register writes; a new edge wins over a simultaneous write-1-to-clear.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      gpo     <= 16'h0000;
      mask    <= 16'h0000;
      pending <= 16'h0000;
    end else begin
      if (gpio_hit && wr) begin
        case (goff[2:0])
          3'd2:    gpo[7:0]   <= data_in;
          3'd3:    gpo[15:8]  <= data_in;
          3'd4:    mask[7:0]  <= data_in;
          3'd5:    mask[15:8] <= data_in;
          default: ;
        endcase
      end
      pending <= (pending & ~w1c) | (rise & mask);
    end
  end

  // Route registers keep only the enable bit and the 2-bit target line.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      route_gpio  <= 8'h00;
      route_uart  <= 8'h00;
      route_timer <= 8'h00;
    end else if (int_hit && wr) begin
      case (ioff[1:0])
        2'd0:    route_gpio  <= route_wdata;
        2'd1:    route_uart  <= route_wdata;
        2'd2:    route_timer <= route_wdata;
        default: ;
      endcase
    end
  end

  // Combinational read mux; zero when unselected so the bus can OR peripherals together.
  always_comb begin
    data_out = 8'h00;
    if (gpio_hit) begin
      case (goff[2:0])
        3'd0: data_out = sync_now[7:0];
        3'd1: data_out = sync_now[15:8];
        3'd2: data_out = gpo[7:0];
        3'd3: data_out = gpo[15:8];
        3'd4: data_out = mask[7:0];
        3'd5: data_out = mask[15:8];
        3'd6: data_out = pending[7:0];
        3'd7: data_out = pending[15:8];
        default: data_out = 8'h00;
      endcase
    end else if (int_hit) begin
      case (ioff[1:0])
        2'd0:    data_out = route_gpio;
        2'd1:    data_out = route_uart;
        2'd2:    data_out = route_timer;
        default: data_out = 8'h00;
      endcase
    end
  end

  // Interrupt outputs: each enabled source ORs onto its selected CPU line.
  always_comb begin
    gpio_int = |(pending & mask);
    cpu_int  = 4'b0000;
    for (int i = 0; i < 4; i++) begin
      if (gpio_int && route_gpio[7] && route_gpio[1:0] == 2'(i))
        cpu_int[i] = 1'b1;
      if (uart_int_in && route_uart[7] && route_uart[1:0] == 2'(i))
        cpu_int[i] = 1'b1;
      if (timer_int_in && route_timer[7] && route_timer[1:0] == 2'(i))
        cpu_int[i] = 1'b1;
    end
  end

endmodule

// File: tb/tb_reflet_gpio_int_periph.sv
// tb/tb_reflet_gpio_int_periph.sv - directed self-checking bench for reflet_gpio_int_periph
module tb_reflet_gpio_int_periph;

  logic        clk = 1'b0;
  logic        reset;
  logic        enable;
  logic [6:0]  addr;
  logic        write_en;
  logic [7:0]  data_in;
  logic [7:0]  data_out;
  logic [15:0] gpi;
  logic [15:0] gpo;
  logic        uart_int_in;
  logic        timer_int_in;
  logic        gpio_int;
  logic [3:0]  cpu_int;

  int total = 0;
  int bad   = 0;

  reflet_gpio_int_periph dut (
    .clk(clk), .reset(reset), .enable(enable), .addr(addr), .write_en(write_en),
    .data_in(data_in), .data_out(data_out), .gpi(gpi), .gpo(gpo),
    .uart_int_in(uart_int_in), .timer_int_in(timer_int_in),
    .gpio_int(gpio_int), .cpu_int(cpu_int)
  );

  always #5 clk = ~clk;

  // Single comparison point used by every directed step.
  task automatic chk(input string tag, input logic [15:0] obs, input logic [15:0] exp);
    total++;
    assert (obs === exp) else begin
      bad++;
      $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
    end
  endtask

  task automatic wr(input logic [6:0] a, input logic [7:0] d);
    @(negedge clk);
    enable = 1'b1; write_en = 1'b1; addr = a; data_in = d;
    @(negedge clk);
    enable = 1'b0; write_en = 1'b0; addr = 7'h00; data_in = 8'h00;
  endtask

  task automatic rd(input string tag, input logic [6:0] a, input logic [7:0] exp);
    @(negedge clk);
    enable = 1'b1; write_en = 1'b0; addr = a;
    #1;
    chk(tag, {8'h00, data_out}, {8'h00, exp});
    enable = 1'b0;
  endtask

  task automatic idle(input int n);
    repeat (n) @(negedge clk);
  endtask

  initial begin
    reset = 1'b0; enable = 1'b0; addr = 7'h00; write_en = 1'b0; data_in = 8'h00;
    gpi = 16'hFFFF; uart_int_in = 1'b0; timer_int_in = 1'b0;

    // Reset state
    idle(3);
    chk("rst_gpo", gpo, 16'h0000);
    chk("rst_cpu_int", {12'h000, cpu_int}, 16'h0000);
    chk("rst_gpio_int", {15'h0000, gpio_int}, 16'h0000);
    enable = 1'b1; addr = 7'h00; #1;
    chk("rst_gpi_lo", {8'h00, data_out}, 16'h0000);
    addr = 7'h06; #1;
    chk("rst_pend_lo", {8'h00, data_out}, 16'h0000);
    enable = 1'b0;
    reset = 1'b1;
    #1;
    enable = 1'b1; addr = 7'h01; #1;
    chk("rel_gpi_hi", {8'h00, data_out}, 16'h0000);
    enable = 1'b0;
    gpi = 16'h0000;
    idle(4);

    // GPO write/readback and bus idle value
    wr(7'h02, 8'h5A);
    wr(7'h03, 8'hC3);
    chk("gpo_val", gpo, 16'hC35A);
    rd("gpo_rd_lo", 7'h02, 8'h5A);
    rd("gpo_rd_hi", 7'h03, 8'hC3);
    @(negedge clk); enable = 1'b0; addr = 7'h02; #1;
    chk("dis_rd", {8'h00, data_out}, 16'h0000);

    // GPI read after sync; with mask 0 nothing becomes pending
    @(negedge clk); gpi = 16'hABCD;
    idle(3);
    rd("gpi_lo", 7'h00, 8'hCD);
    rd("gpi_hi", 7'h01, 8'hAB);
    rd("nomask_pend_lo", 7'h06, 8'h00);
    rd("nomask_pend_hi", 7'h07, 8'h00);
    chk("nomask_cpu_int", {12'h000, cpu_int}, 16'h0000);
    wr(7'h00, 8'h00);
    rd("ro_write_ign", 7'h00, 8'hCD);
    @(negedge clk); gpi = 16'h0000;
    idle(4);

    // Edge interrupt routed to IRQ1
    wr(7'h04, 8'h01);
    wr(7'h08, 8'h81);
    chk("pre_edge_int", {15'h0000, gpio_int}, 16'h0000);
    @(negedge clk); gpi = 16'h0001;
    idle(4);
    chk("edge_gpio_int", {15'h0000, gpio_int}, 16'h0001);
    chk("edge_cpu_int", {12'h000, cpu_int}, 16'h0002);
    rd("edge_pend", 7'h06, 8'h01);
    @(negedge clk); gpi = 16'h0000;
    idle(4);
    chk("fall_keeps", {15'h0000, gpio_int}, 16'h0001);
    wr(7'h04, 8'h00);
    chk("unmask_int", {15'h0000, gpio_int}, 16'h0000);
    rd("unmask_pend", 7'h06, 8'h01);
    wr(7'h04, 8'h01);
    wr(7'h06, 8'h00);
    rd("w0_noeffect", 7'h06, 8'h01);
    wr(7'h06, 8'h01);
    chk("w1c_gpio_int", {15'h0000, gpio_int}, 16'h0000);
    chk("w1c_cpu_int", {12'h000, cpu_int}, 16'h0000);
    rd("w1c_pend", 7'h06, 8'h00);

    // Route register reserved bits read as zero
    wr(7'h08, 8'hFF);
    rd("route_rsvd", 7'h08, 8'h83);
    wr(7'h08, 8'h81);
    rd("route_back", 7'h08, 8'h81);

    // Mux: disabled timer route never drives, then OR on a shared line
    wr(7'h09, 8'h83);
    wr(7'h0A, 8'h03);
    @(negedge clk); uart_int_in = 1'b1; timer_int_in = 1'b1; #1;
    chk("mux_uart_only", {12'h000, cpu_int}, 16'h0008);
    wr(7'h0A, 8'h83);
    chk("mux_shared", {12'h000, cpu_int}, 16'h0008);
    @(negedge clk); uart_int_in = 1'b0; #1;
    chk("mux_timer_l3", {12'h000, cpu_int}, 16'h0008);
    wr(7'h0A, 8'h80);
    @(negedge clk); uart_int_in = 1'b1; #1;
    chk("mux_two_lines", {12'h000, cpu_int}, 16'h0009);
    rd("route_timer", 7'h0A, 8'h80);
    rd("unimpl_0b", 7'h0B, 8'h00);
    rd("unimpl_10", 7'h10, 8'h00);

    // Asynchronous reset mid-operation
    @(negedge clk); #2 reset = 1'b0; #1;
    chk("mid_rst_gpo", gpo, 16'h0000);
    chk("mid_rst_cpu", {12'h000, cpu_int}, 16'h0000);
    reset = 1'b1;
    rd("mid_rst_route", 7'h09, 8'h00);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL timeout observed=running expected=finished");
    $fatal(1, "timeout");
  end

endmodule
